vu_vmu_srq_issue: RTL and testbench

//  Store-request issue stage downstream of the vector store controller. Accepts line-granular

---
 rtl/vu_vmu_srq_issue_if.sv | 41 ++++
 rtl/vu_vmu_srq_issue.sv | 150 +++++++++++++++
 tb/tb_vu_vmu_srq_issue.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vu_vmu_srq_issue_if.sv
// Store-request issue bus: line-granular enqueue port from the vector store
// controller, plus the memory request/response port the issue stage drives.
// master = upstream/memory side, slave = the issue stage itself.
interface vu_vmu_srq_issue_if #(
  parameter int TAG_SZ = 4
);
  // Enqueue side (from the vector store controller)
  logic [27:0]       srq_enq_addr_bits;
  logic [127:0]      srq_enq_data_bits;
  logic [15:0]       srq_enq_wmask_bits;
  logic              srq_enq_val;
  logic              srq_enq_rdy;

  // Memory request side
  logic [27:0]       mem_req_addr;
  logic [127:0]      mem_req_data;
  logic [15:0]       mem_req_wmask;
  logic [TAG_SZ-1:0] mem_req_tag;
  logic              mem_req_val;
  logic              mem_req_rdy;

  // Memory store-ack side
  logic              mem_resp_val;
  logic [TAG_SZ-1:0] mem_resp_tag;

  modport master (
    output srq_enq_addr_bits, srq_enq_data_bits, srq_enq_wmask_bits, srq_enq_val,
    input  srq_enq_rdy,
    input  mem_req_addr, mem_req_data, mem_req_wmask, mem_req_tag, mem_req_val,
    output mem_req_rdy,
    output mem_resp_val, mem_resp_tag
  );

  modport slave (
    input  srq_enq_addr_bits, srq_enq_data_bits, srq_enq_wmask_bits, srq_enq_val,
    output srq_enq_rdy,
    output mem_req_addr, mem_req_data, mem_req_wmask, mem_req_tag, mem_req_val,
    input  mem_req_rdy,
    input  mem_resp_val, mem_resp_tag
  );
endinterface

// File: rtl/vu_vmu_srq_issue.sv
// Vector store-request issue stage.
// Buffers line-granular store requests in a DEPTH-entry FIFO, issues them in
// order to memory with a rolling tag, and tracks un-acked stores so the VMU
// busy/fence logic can see when all stores have drained (store_pending).
// Optional build macro: VMU_SRQ_MERGE_EN enables write-combining into the
// FIFO tail entry when a new request targets the same line address.
module vu_vmu_srq_issue #(
  parameter int DEPTH     = 4,  // power of two, >= 2
  parameter int TAG_SZ    = 4,
  parameter int MAX_OUTST = 8   // 1 .. 2**TAG_SZ
) (
  input  logic              clk,
  input  logic              reset,            // async, active-low
  vu_vmu_srq_issue_if.slave bus,
  output logic              store_pending,
  output logic              err_resp_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTST + 1);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [OUT_W-1:0] MAX_C   = OUT_W'(MAX_OUTST);

  // Entry storage
  logic [27:0]  addr_q  [DEPTH];
  logic [127:0] data_q  [DEPTH];
  logic [15:0]  wmask_q [DEPTH];

  // Control state
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [OUT_W-1:0]  outst_cnt;
  logic [TAG_SZ-1:0] tag_cnt;
  logic              err_q;

  // Decoded per-cycle controls
  logic [PTR_W-1:0] tail_ptr;
  logic             not_full;
  logic             not_empty;
  logic             req_val;
  logic             deq_fire;
  logic             merge_hit;
  logic             enq_rdy;
  logic             enq_fire;
  logic             merge_fire;
  logic             wr_en;

  // The ack tag is informational only; nothing in this stage consumes it.
  logic unused_resp_tag;
  assign unused_resp_tag = ^bus.mem_resp_tag;

  assign tail_ptr  = wr_ptr - PTR_W'(1);
  assign not_full  = (count != DEPTH_C);
  assign not_empty = (count != '0);

  // Issue is throttled by the in-flight limit; everything is forced idle
  // while reset is asserted, since the state clears asynchronously.
  assign req_val  = reset & not_empty & (outst_cnt < MAX_C);
  assign deq_fire = req_val & bus.mem_req_rdy;

  // Enqueue decode: merge detection, ready, and whether a new slot is written.
  // NOTE: every output of an always_comb gets a default first so no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    merge_hit  = 1'b0;
    enq_rdy    = 1'b0;
    enq_fire   = 1'b0;
    merge_fire = 1'b0;
    wr_en      = 1'b0;
`ifdef VMU_SRQ_MERGE_EN
    // The tail may only absorb a request if it is not leaving this cycle;
    // with one entry the tail is the head.
    merge_hit = bus.srq_enq_val & not_empty
              & (bus.srq_enq_addr_bits == addr_q[tail_ptr])
              & ~((count == CNT_W'(1)) & deq_fire);
    enq_rdy   = reset & (not_full | merge_hit);
`else
    enq_rdy   = reset & not_full;
`endif
    enq_fire   = bus.srq_enq_val & enq_rdy;
    merge_fire = enq_fire & merge_hit;
    // A zero-mask request is accepted but has nothing to store.
    wr_en      = enq_fire & ~merge_hit & (bus.srq_enq_wmask_bits != '0);
  end

  // Pointer, occupancy, in-flight, tag and error bookkeeping.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      outst_cnt <= '0;
      tag_cnt   <= '0;
      err_q     <= 1'b0;
    end else begin
      if (wr_en)    wr_ptr  <= wr_ptr + PTR_W'(1);
      if (deq_fire) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        tag_cnt <= tag_cnt + TAG_SZ'(1);
      end
      count <= count + CNT_W'(wr_en) - CNT_W'(deq_fire);

      // An ack landing with an issue in the same cycle cancels out.
      if (deq_fire && !bus.mem_resp_val) begin
        outst_cnt <= outst_cnt + OUT_W'(1);
      end else if (!deq_fire && bus.mem_resp_val) begin
        if (outst_cnt != '0) outst_cnt <= outst_cnt - OUT_W'(1);
        else                 err_q     <= 1'b1;
      end
    end
  end

  // Entry write and tail write-combining.
  // NOTE: the entry array has no reset; an entry is only observable after it
  // has been written, so clearing it would cost flops and buy nothing.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      addr_q[wr_ptr]  <= bus.srq_enq_addr_bits;
      data_q[wr_ptr]  <= bus.srq_enq_data_bits;
      wmask_q[wr_ptr] <= bus.srq_enq_wmask_bits;
    end
`ifdef VMU_SRQ_MERGE_EN
    else if (merge_fire) begin
      for (int i = 0; i < 16; i++) begin
        if (bus.srq_enq_wmask_bits[i]) begin
          data_q[tail_ptr][8*i +: 8] <= bus.srq_enq_data_bits[8*i +: 8];
        end
      end
      wmask_q[tail_ptr] <= wmask_q[tail_ptr] | bus.srq_enq_wmask_bits;
    end
`endif
  end

  // Head entry drives the request port directly from storage.
  assign bus.srq_enq_rdy   = enq_rdy;
  assign bus.mem_req_val   = req_val;
  assign bus.mem_req_addr  = addr_q[rd_ptr];
  assign bus.mem_req_data  = data_q[rd_ptr];
  assign bus.mem_req_wmask = wmask_q[rd_ptr];
  assign bus.mem_req_tag   = tag_cnt;

  assign store_pending      = reset & (not_empty | (outst_cnt != '0));
  assign err_resp_underflow = err_q;

endmodule

// File: tb/tb_vu_vmu_srq_issue.sv
// Directed testbench for vu_vmu_srq_issue (DEPTH=4, TAG_SZ=4, MAX_OUTST=8).
// Expectations follow VMU_SRQ_MERGE_EN if it is defined for the build.
module tb_vu_vmu_srq_issue;

  logic clk = 1'b0;
  logic reset;
  logic store_pending;
  logic err_resp_underflow;

  int checks   = 0;
  int failures = 0;
  int issued   = 0;
  int base;

`ifdef VMU_SRQ_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  vu_vmu_srq_issue_if #(.TAG_SZ(4)) bus ();

  vu_vmu_srq_issue #(.DEPTH(4), .TAG_SZ(4), .MAX_OUTST(8)) dut (
    .clk                (clk),
    .reset              (reset),
    .bus                (bus.slave),
    .store_pending      (store_pending),
    .err_resp_underflow (err_resp_underflow)
  );

  always #5 clk = ~clk;

  // Count issued requests independently of the DUT's internal state.
  always @(posedge clk) if (reset && bus.mem_req_val && bus.mem_req_rdy) issued++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.srq_enq_val        = 1'b0;
    bus.srq_enq_addr_bits  = '0;
    bus.srq_enq_data_bits  = '0;
    bus.srq_enq_wmask_bits = '0;
    bus.mem_req_rdy        = 1'b0;
    bus.mem_resp_val       = 1'b0;
    bus.mem_resp_tag       = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic enq(input logic [27:0] a, input logic [127:0] d, input logic [15:0] m);
    bus.srq_enq_val        = 1'b1;
    bus.srq_enq_addr_bits  = a;
    bus.srq_enq_data_bits  = d;
    bus.srq_enq_wmask_bits = m;
    tick();
    bus.srq_enq_val = 1'b0;
  endtask

  function automatic logic [127:0] pat(input int i);
    logic [127:0] d;
    d = {4{32'hC3A5_0000 + 32'(i)}};
    return d;
  endfunction

  initial begin
    // ---------------- reset / idle ----------------
    idle_inputs();
    reset = 1'b0;
    repeat (5) tick();
    check("rst_enq_rdy",  bus.srq_enq_rdy, 0);
    check("rst_req_val",  bus.mem_req_val, 0);
    check("rst_pending",  store_pending, 0);
    check("rst_err",      err_resp_underflow, 0);
    reset = 1'b1;
    #1;
    check("idle_enq_rdy", bus.srq_enq_rdy, 1);
    check("idle_req_val", bus.mem_req_val, 0);
    check("idle_pending", store_pending, 0);

    // ---------------- fill then in-order drain ----------------
    for (int i = 0; i < 4; i++) begin
      bus.srq_enq_val        = 1'b1;
      bus.srq_enq_addr_bits  = 28'h10 + 28'(i);
      bus.srq_enq_data_bits  = pat(i);
      bus.srq_enq_wmask_bits = 16'hFFFF;
      #1;
      if (i == 0) check("no_bypass_val", bus.mem_req_val, 0);
      check("fill_enq_rdy", bus.srq_enq_rdy, 1);
      tick();
    end
    bus.srq_enq_val = 1'b0;
    #1;
    check("full_enq_rdy",  bus.srq_enq_rdy, 0);
    check("full_req_val",  bus.mem_req_val, 1);
    check("full_head_tag", bus.mem_req_tag, 0);
    // Same address as the tail: only a merging build accepts it while full.
    bus.srq_enq_val        = 1'b1;
    bus.srq_enq_addr_bits  = 28'h13;
    bus.srq_enq_wmask_bits = 16'h0001;
    #1;
    check("full_tail_addr_rdy", bus.srq_enq_rdy, MERGE);
    bus.srq_enq_addr_bits  = 28'h14;
    #1;
    check("full_other_addr_rdy", bus.srq_enq_rdy, 0);
    bus.srq_enq_val = 1'b0;

    tick();
    bus.mem_req_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("drain_val",  bus.mem_req_val, 1);
      check("drain_addr", bus.mem_req_addr, 28'h10 + 28'(i));
      check("drain_data", bus.mem_req_data, pat(i));
      check("drain_tag",  bus.mem_req_tag, 4'(i));
      tick();
    end
    bus.mem_req_rdy = 1'b0;
    #1;
    check("drained_val",     bus.mem_req_val, 0);
    check("drained_pending", store_pending, 1);
    check("drained_enq_rdy", bus.srq_enq_rdy, 1);

    // Four acks retire the four stores; a fifth underflows.
    bus.mem_resp_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("ack_pending", store_pending, 1);
      tick();
    end
    check("acked_pending", store_pending, 0);
    check("acked_err",     err_resp_underflow, 0);
    tick();
    bus.mem_resp_val = 1'b0;
    #1;
    check("underflow_err", err_resp_underflow, 1);
    tick();
    check("underflow_sticky", err_resp_underflow, 1);

    // ---------------- throttle / ack-issue collision ----------------
    do_reset();
    check("reset_clears_err", err_resp_underflow, 0);
    base = issued;
    bus.mem_req_rdy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.srq_enq_val        = 1'b1;
      bus.srq_enq_addr_bits  = 28'h30 + 28'(i);
      bus.srq_enq_data_bits  = pat(16 + i);
      bus.srq_enq_wmask_bits = 16'hFFFF;
      #1;
      check("stream_enq_rdy", bus.srq_enq_rdy, 1);
      if (i >= 1) begin
        check("stream_val",  bus.mem_req_val, 1);
        check("stream_addr", bus.mem_req_addr, 28'h30 + 28'(i - 1));
        check("stream_tag",  bus.mem_req_tag, 4'(i - 1));
      end
      tick();
    end
    bus.srq_enq_val = 1'b0;
    #1;
    check("throttle_val",     bus.mem_req_val, 0);
    check("throttle_pending", store_pending, 1);
    tick();
    check("throttle_val_hold", bus.mem_req_val, 0);
    check("throttle_issued",   32'(issued - base), 8);

    bus.mem_resp_val = 1'b1;          // 8 -> 7 outstanding
    tick();
    check("unthrottle_val",  bus.mem_req_val, 1);
    check("unthrottle_tag",  bus.mem_req_tag, 8);
    check("unthrottle_addr", bus.mem_req_addr, 28'h38);
    tick();                           // issue + ack together: stays 7
    bus.mem_resp_val = 1'b0;
    enq(28'h40, pat(40), 16'hFFFF);
    #1;
    check("collide_val",  bus.mem_req_val, 1);
    check("collide_tag",  bus.mem_req_tag, 9);
    check("collide_addr", bus.mem_req_addr, 28'h40);
    tick();                           // 8 outstanding, FIFO empty
    check("post_collide_val", bus.mem_req_val, 0);
    bus.mem_resp_val = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("retire_pending", store_pending, 1);
      tick();
    end
    bus.mem_resp_val = 1'b0;
    #1;
    check("retired_pending", store_pending, 0);
    check("retired_err",     err_resp_underflow, 0);
    check("retired_issued",  32'(issued - base), 10);

    // ---------------- tail write-combining ----------------
    do_reset();
    enq(28'h20, {16{8'hAA}}, 16'h000F);
    enq(28'h20, {16{8'hBB}}, 16'h00F0);
    #1;
    check("merge_head_val",  bus.mem_req_val, 1);
    check("merge_head_addr", bus.mem_req_addr, 28'h20);
    if (MERGE) begin
      check("merge_wmask", bus.mem_req_wmask, 16'h00FF);
      check("merge_data",  bus.mem_req_data, 128'hAAAAAAAA_AAAAAAAA_BBBBBBBB_AAAAAAAA);
    end else begin
      check("nomerge_wmask0", bus.mem_req_wmask, 16'h000F);
      check("nomerge_data0",  bus.mem_req_data, {16{8'hAA}});
    end
    bus.mem_req_rdy = 1'b1;
    tick();
    bus.mem_req_rdy = 1'b0;
    #1;
    check("merge_entries_left", bus.mem_req_val, !MERGE);
    if (!MERGE) begin
      check("nomerge_wmask1", bus.mem_req_wmask, 16'h00F0);
      check("nomerge_data1",  bus.mem_req_data, {16{8'hBB}});
    end

    // ---------------- zero mask / mid-operation reset ----------------
    do_reset();
    enq(28'h50, pat(50), 16'h0000);
    #1;
    check("zmask_val",     bus.mem_req_val, 0);
    check("zmask_pending", store_pending, 0);
    check("zmask_enq_rdy", bus.srq_enq_rdy, 1);
    for (int i = 1; i < 4; i++) enq(28'h50 + 28'(i), pat(50 + i), 16'hFFFF);
    #1;
    check("q3_val",     bus.mem_req_val, 1);
    check("q3_addr",    bus.mem_req_addr, 28'h51);
    check("q3_enq_rdy", bus.srq_enq_rdy, 1);
    reset = 1'b0;
    #1;
    check("midrst_val",     bus.mem_req_val, 0);
    check("midrst_enq_rdy", bus.srq_enq_rdy, 0);
    check("midrst_pending", store_pending, 0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("postrst_val",     bus.mem_req_val, 0);
    check("postrst_pending", store_pending, 0);
    check("postrst_enq_rdy", bus.srq_enq_rdy, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
